// File: rtl/pulse_evt_collector_pkg.sv
// Shared encodings for the pulse event collector: close causes and FSM states.
package pulse_pkg;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_WIN   = 2'b01;
    localparam logic [1:0] CAUSE_THR   = 2'b10;
    localparam logic [1:0] CAUSE_FLUSH = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        PEND = 2'b10
    } state_t;

endpackage

// File: rtl/pulse_evt_collector_if.sv
// Record channel from the event collector towards the status/CSR logic.
interface pulse_evt_collector_if #(
    parameter int CNT_W = 8
) ();
    import pulse_pkg::*;

    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic             out_sat;
    logic [1:0]       out_cause;

    modport master (
        output out_valid,
        output out_count,
        output out_sat,
        output out_cause,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_count,
        input  out_sat,
        input  out_cause,
        output out_ready
    );

endinterface

// File: rtl/pulse_evt_collector_sat_counter.sv
// Saturating up-counter with clear and sticky overflow; exposes the next value
// so the owner can capture a count that includes the current increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clkb,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt_next,
    output logic         ovf_next
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] cnt;
    logic         ovf;
    logic         at_max;

    always_comb begin
        at_max   = (cnt == MAX);
        cnt_next = (inc && !at_max) ? cnt + W'(1) : cnt;
        ovf_next = ovf | (inc & at_max);
    end

    always_ff @(posedge clkb) begin
        if (rst || clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            cnt <= cnt_next;
            ovf <= ovf_next;
        end
    end

endmodule

// File: rtl/pulse_evt_collector.sv
// Counts synchronized pulse events per window and emits one record per closed
// window; holds the window open (PEND) while the record channel is stalled.
module pulse_evt_collector
    import pulse_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int WIN_W   = 16,
    parameter int WIN_LEN = 1000,
    parameter int THRESH  = 200
) (
    input  logic clkb,
    input  logic rst,
    input  logic en,
    input  logic flush,
    input  logic pulse_in,
    pulse_evt_collector_if.master rec
);

    localparam logic [CNT_W-1:0] THR      = CNT_W'(THRESH);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);

    state_t           state, state_nxt;
    logic [WIN_W-1:0] timer, timer_nxt;
    logic [1:0]       cause_q, cause_nxt, close_cause;
    logic [CNT_W-1:0] acc_nxt;
    logic             sat_nxt;
    logic             acc_clr, acc_inc, out_free, load;

    assign acc_inc  = pulse_in & en & (state != IDLE);
    assign out_free = !rec.out_valid || rec.out_ready;

    sat_counter #(.W(CNT_W)) u_acc (
        .clkb     (clkb),
        .rst      (rst),
        .clr      (acc_clr),
        .inc      (acc_inc),
        .cnt_next (acc_nxt),
        .ovf_next (sat_nxt)
    );

    always_ff @(posedge clkb) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        cause_nxt   = cause_q;
        close_cause = CAUSE_NONE;
        acc_clr     = 1'b0;
        load        = 1'b0;
        case (state)
            IDLE: begin
                acc_clr   = 1'b1;
                timer_nxt = '0;
                cause_nxt = CAUSE_NONE;
                if (en) state_nxt = RUN;
            end
            RUN: begin
                if (!en) begin
                    state_nxt = IDLE;
                    acc_clr   = 1'b1;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + WIN_W'(1);
                    if (flush)                close_cause = CAUSE_FLUSH;
                    else if (acc_nxt >= THR)  close_cause = CAUSE_THR;
                    else if (timer == WIN_LAST) close_cause = CAUSE_WIN;
                    if (close_cause != CAUSE_NONE) begin
                        if (out_free) begin
                            load      = 1'b1;
                            acc_clr   = 1'b1;
                            timer_nxt = '0;
                        end else begin
                            state_nxt = PEND;
                            cause_nxt = close_cause;
                            timer_nxt = timer;
                        end
                    end
                end
            end
            PEND: begin
                if (!en) begin
                    state_nxt = IDLE;
                    acc_clr   = 1'b1;
                    timer_nxt = '0;
                end else begin
                    // Latched cause can only be upgraded: WIN -> THR -> FLUSH.
                    if (flush)
                        close_cause = CAUSE_FLUSH;
                    else if (cause_q == CAUSE_WIN && acc_nxt >= THR)
                        close_cause = CAUSE_THR;
                    else
                        close_cause = cause_q;
                    cause_nxt = close_cause;
                    if (out_free) begin
                        load      = 1'b1;
                        acc_clr   = 1'b1;
                        timer_nxt = '0;
                        state_nxt = RUN;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clkb) begin
        if (rst) begin
            timer         <= '0;
            cause_q       <= CAUSE_NONE;
            rec.out_valid <= 1'b0;
            rec.out_count <= '0;
            rec.out_sat   <= 1'b0;
            rec.out_cause <= CAUSE_NONE;
        end else begin
            timer   <= timer_nxt;
            cause_q <= cause_nxt;
            if (load) begin
                rec.out_valid <= 1'b1;
                rec.out_count <= acc_nxt;
                rec.out_sat   <= sat_nxt;
                rec.out_cause <= close_cause;
            end else if (rec.out_ready) begin
                rec.out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_evt_collector.sv
// Directed bench: dut_a (THRESH=4) covers window/threshold/flush/reset/enable,
// dut_b (THRESH=7) covers stall, PEND accumulation and saturation.
module tb_pulse_evt_collector;

    logic clkb = 1'b0;
    logic rst, en, flush, pulse_in;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clkb = ~clkb;

    pulse_evt_collector_if #(.CNT_W(3)) bus_a ();
    pulse_evt_collector_if #(.CNT_W(3)) bus_b ();

    pulse_evt_collector #(.CNT_W(3), .WIN_W(4), .WIN_LEN(8), .THRESH(4)) dut_a (
        .clkb(clkb), .rst(rst), .en(en), .flush(flush), .pulse_in(pulse_in), .rec(bus_a)
    );

    pulse_evt_collector #(.CNT_W(3), .WIN_W(4), .WIN_LEN(8), .THRESH(7)) dut_b (
        .clkb(clkb), .rst(rst), .en(en), .flush(flush), .pulse_in(pulse_in), .rec(bus_b)
    );

    task automatic step();
        @(posedge clkb);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; flush = 1'b0; pulse_in = 1'b0;
        bus_a.out_ready = 1'b1; bus_b.out_ready = 1'b1;
        step(); step();
        n_checks++;
        if ({bus_a.out_valid, bus_a.out_count, bus_a.out_sat, bus_a.out_cause} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_a: v=%b c=%0d s=%b cause=%b, expected all 0",
                     bus_a.out_valid, bus_a.out_count, bus_a.out_sat, bus_a.out_cause);
        end
        n_checks++;
        if ({bus_b.out_valid, bus_b.out_count, bus_b.out_sat, bus_b.out_cause} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_b: v=%b c=%0d s=%b cause=%b, expected all 0",
                     bus_b.out_valid, bus_b.out_count, bus_b.out_sat, bus_b.out_cause);
        end
        rst = 1'b0;
    endtask

    task automatic test_window();
        en = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            pulse_in = (k == 1 || k == 3 || k == 5);
            step();
            if (k == 6) begin
                n_checks++;
                if (bus_a.out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL window_early: valid=%b, expected 0", bus_a.out_valid);
                end
            end
        end
        pulse_in = 1'b0;
        n_checks++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_count !== 3'd3 || bus_a.out_sat !== 1'b0 ||
            bus_a.out_cause !== 2'b01) begin
            n_fail++;
            $display("FAIL window_rec: v=%b c=%0d s=%b cause=%b, expected 1 3 0 01",
                     bus_a.out_valid, bus_a.out_count, bus_a.out_sat, bus_a.out_cause);
        end
    endtask

    task automatic test_threshold();
        for (int k = 0; k < 4; k++) begin
            pulse_in = 1'b1;
            step();
            if (k < 3) begin
                n_checks++;
                if (bus_a.out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL thr_early k=%0d: valid=%b, expected 0", k, bus_a.out_valid);
                end
            end
        end
        pulse_in = 1'b0;
        n_checks++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_count !== 3'd4 || bus_a.out_sat !== 1'b0 ||
            bus_a.out_cause !== 2'b10) begin
            n_fail++;
            $display("FAIL thr_rec: v=%b c=%0d s=%b cause=%b, expected 1 4 0 10",
                     bus_a.out_valid, bus_a.out_count, bus_a.out_sat, bus_a.out_cause);
        end
        for (int k = 0; k < 8; k++) begin
            step();
            if (k == 6) begin
                n_checks++;
                if (bus_a.out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL thr_restart_early: valid=%b, expected 0", bus_a.out_valid);
                end
            end
        end
        n_checks++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_count !== 3'd0 || bus_a.out_cause !== 2'b01) begin
            n_fail++;
            $display("FAIL thr_restart_rec: v=%b c=%0d cause=%b, expected 1 0 01",
                     bus_a.out_valid, bus_a.out_count, bus_a.out_cause);
        end
    endtask

    task automatic test_flush();
        en = 1'b0;
        step();
        en = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            pulse_in = (k == 1 || k == 3 || k == 5 || k == 7);
            flush    = (k == 7);
            step();
        end
        pulse_in = 1'b0;
        n_checks++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_count !== 3'd4 || bus_a.out_cause !== 2'b11) begin
            n_fail++;
            $display("FAIL flush_prio: v=%b c=%0d cause=%b, expected 1 4 11",
                     bus_a.out_valid, bus_a.out_count, bus_a.out_cause);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_checks++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_count !== 3'd0 || bus_a.out_cause !== 2'b11) begin
            n_fail++;
            $display("FAIL flush_empty: v=%b c=%0d cause=%b, expected 1 0 11",
                     bus_a.out_valid, bus_a.out_count, bus_a.out_cause);
        end
        step();
        n_checks++;
        if (bus_a.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_drain: valid=%b, expected 0", bus_a.out_valid);
        end
    endtask

    task automatic test_stall_sat();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus_b.out_ready = 1'b0;
        en = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            pulse_in = (k < 2);
            step();
        end
        pulse_in = 1'b0;
        n_checks++;
        if (bus_b.out_valid !== 1'b1 || bus_b.out_count !== 3'd2 || bus_b.out_cause !== 2'b01) begin
            n_fail++;
            $display("FAIL stall_rec1: v=%b c=%0d cause=%b, expected 1 2 01",
                     bus_b.out_valid, bus_b.out_count, bus_b.out_cause);
        end
        for (int k = 0; k < 8; k++) step();
        for (int k = 0; k < 9; k++) begin
            pulse_in = 1'b1;
            step();
        end
        pulse_in = 1'b0;
        n_checks++;
        if (bus_b.out_valid !== 1'b1 || bus_b.out_count !== 3'd2 || bus_b.out_sat !== 1'b0 ||
            bus_b.out_cause !== 2'b01) begin
            n_fail++;
            $display("FAIL stall_hold: v=%b c=%0d s=%b cause=%b, expected 1 2 0 01",
                     bus_b.out_valid, bus_b.out_count, bus_b.out_sat, bus_b.out_cause);
        end
        bus_b.out_ready = 1'b1;
        step();
        n_checks++;
        if (bus_b.out_valid !== 1'b1 || bus_b.out_count !== 3'd7 || bus_b.out_sat !== 1'b1 ||
            bus_b.out_cause !== 2'b10) begin
            n_fail++;
            $display("FAIL stall_rec2: v=%b c=%0d s=%b cause=%b, expected 1 7 1 10",
                     bus_b.out_valid, bus_b.out_count, bus_b.out_sat, bus_b.out_cause);
        end
        step();
        n_checks++;
        if (bus_b.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_drain: valid=%b, expected 0", bus_b.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus_a.out_ready = 1'b0;
        en = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            pulse_in = (k < 2);
            step();
        end
        for (int k = 0; k < 3; k++) begin
            pulse_in = 1'b1;
            step();
        end
        pulse_in = 1'b0;
        n_checks++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_count !== 3'd2) begin
            n_fail++;
            $display("FAIL rst_pre: v=%b c=%0d, expected 1 2", bus_a.out_valid, bus_a.out_count);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus_a.out_ready = 1'b1;
        n_checks++;
        if ({bus_a.out_valid, bus_a.out_count, bus_a.out_sat, bus_a.out_cause} !== 7'b0) begin
            n_fail++;
            $display("FAIL rst_mid: v=%b c=%0d s=%b cause=%b, expected all 0",
                     bus_a.out_valid, bus_a.out_count, bus_a.out_sat, bus_a.out_cause);
        end
        seen = 1'b0;
        step();
        for (int k = 0; k < 7; k++) begin
            step();
            if (bus_a.out_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_rec: stale record seen=%b, expected 0", seen);
        end
    endtask

    task automatic test_enable();
        logic seen;
        en = 1'b0;
        step(); step();
        en = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            pulse_in = (k < 2);
            step();
        end
        en = 1'b0;
        pulse_in = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (bus_a.out_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL en_drop: record seen=%b, expected 0", seen);
        end
        en = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            pulse_in = (k == 2);
            step();
        end
        pulse_in = 1'b0;
        n_checks++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_count !== 3'd1 || bus_a.out_cause !== 2'b01) begin
            n_fail++;
            $display("FAIL en_restart: v=%b c=%0d cause=%b, expected 1 1 01",
                     bus_a.out_valid, bus_a.out_count, bus_a.out_cause);
        end
    endtask

    initial begin
        test_reset();
        test_window();
        test_threshold();
        test_flush();
        test_stall_sat();
        test_reset_mid();
        test_enable();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/pulse_evt_collector.md
Name: pulse_evt_collector

Overview:
- Slow-domain consumer placed directly after the fast-to-slow pulse synchronizer.
- Takes the single-cycle `pulse_outb` events and counts them over a programmable time window.
- Emits one record per closed window on a valid/ready interface towards the status/CSR logic.
- Ensures no counted event is lost while the downstream side is stalled.

Parameters:
- CNT_W, 8: width of the event count in a record; the count saturates at 2^CNT_W-1.
- WIN_W, 16: width of the window timer.
- WIN_LEN, 1000: window length in clkb cycles; legal range 2..2^WIN_W-1.
- THRESH, 200: early-close threshold on the count; legal range 1..2^CNT_W-1.

Ports:
- clkb  in  1  slow-domain clock; the only clock of the block.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  collection enable.
- flush  in  1  single-cycle request to close the current window immediately.
- pulse_in  in  1  event strobe from the synchronizer's pulse_outb; single cycle.
- out_valid  out  1  a record is held on the out_* lines.
- out_ready  in  1  consumer accepts the record.
- out_count  out  CNT_W  number of events in the closed window.
- out_sat  out  1  the count saturated in that window.
- out_cause  out  2  close reason: 01 window, 10 threshold, 11 flush.

Behaviour:
- Reset: out_valid=0, out_count=0, out_sat=0, out_cause=00, internal acc=0, timer=0, sat=0, state=IDLE. A reset asserted mid-window or mid-stall discards everything, including a held record.
- State IDLE:
  - Entered when en=0.
  - acc, timer and sat are held at 0; pulse_in and flush are ignored.
  - The output register is unaffected, so a held record still drains.
  - en=1 moves to RUN on the next cycle.
  - en falling in RUN or PEND returns to IDLE and discards the partial window without emitting a record.
- State RUN:
  - timer increments every cycle.
  - When pulse_in=1, acc increments with saturation. If acc is already 2^CNT_W-1 and a pulse arrives, sat is set.
  - Close condition is evaluated each cycle using the post-increment acc (acc_nxt):
    - flush=1 gives cause 11;
    - else acc_nxt>=THRESH gives cause 10;
    - else timer==WIN_LEN-1 gives cause 01.
    - Priority is FLUSH > THRESH > WINDOW.
  - A pulse arriving on the closing cycle is counted in the closing record.
- Close with output free:
  - "Free" means out_valid=0, or out_valid&&out_ready in the same cycle.
  - On the next edge the output register loads {acc_nxt, sat_nxt, cause} and out_valid=1.
  - acc, timer and sat clear; state stays RUN. Latency is 1 cycle from the close condition to out_valid.
- Close with output busy: go to PEND and latch the cause.
- State PEND:
  - timer is frozen.
  - Pulses keep accumulating into the same acc, saturating with sat sticky.
  - A later flush upgrades the latched cause to 11. A THRESH crossing upgrades 01 to 10; it never downgrades.
  - On the first cycle the output is free, the record loads (including any pulse that cycle), acc/timer/sat clear and the state returns to RUN.
- Output handshake:
  - out_* are stable while out_valid=1 and out_ready=0.
  - out_valid drops the cycle after acceptance, unless a new record loads in that same cycle, in which case it stays high with the new contents (back-to-back records allowed).
- flush with acc=0 still emits a record with count 0 and cause 11.
- A pulse_in held high for multiple cycles counts once per cycle; no edge detection is done here.

Decomposition:
- Shared package pulse_pkg holds:
  - cause encodings CAUSE_WIN=2'b01, CAUSE_THR=2'b10, CAUSE_FLUSH=2'b11;
  - state encodings IDLE/RUN/PEND.
- One natural sub-module, sat_counter: a parameterised saturating up-counter with clear and a sticky overflow flag, used for acc/sat.
- Window timer and FSM stay in the top module.

Test Plan (WIN_LEN=8, THRESH=4, CNT_W=3 unless noted):
- Window close: en=1, pulses at timer 1,3,5, out_ready=1 → out_valid for 1 cycle after timer=7 with count=3, cause=01, sat=0; next window starts with acc=0.
- Threshold: 4 pulses on consecutive cycles from timer 0 → record count=4, cause=10, one cycle after the 4th pulse; timer restarts.
- Stall and saturation (THRESH=7):
  - out_ready=0 with a record held; second window closes (cause 01) → PEND.
  - 9 further pulses → acc stops at 7, sat=1, cause upgraded to 10.
  - Raise out_ready → first record accepted, second appears the same cycle with count=7, sat=1, cause=10.
- Flush precedence: flush and the 4th pulse in the same cycle at timer=7 → count=4, cause=11; flush with acc=0 → count=0, cause=11.
- Reset/enable:
  - rst asserted mid-window with out_valid=1 → next cycle out_valid=0, all outputs 0, no record emitted afterwards from the old window.
  - en dropped mid-window with 2 pulses → no record; re-enable → the count starts from 0.
